// File: rtl/sdram_ctrl_pkg.sv
// sdram_ctrl_pkg
//   Shared state encodings and helpers for the SDRAM sequencing controller
//   and its command decoder. The decoder relies on the enum order, so new
//   states must only be appended.
package sdram_ctrl_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_PRECHARGE,
    I_TRP,
    I_AUTO_REFRESH1,
    I_TRF1,
    I_AUTO_REFRESH2,
    I_TRF2,
    I_MRS,
    I_TMRD,
    I_DONE
  } init_state_t;

  typedef enum logic [3:0] {
    W_IDLE,
    W_ACTIVE,
    W_TRCD,
    W_READ,
    W_CL,
    W_RD,
    W_WRITE,
    W_WD,
    W_TDAL,
    W_PRECHARGE,
    W_TRP,
    W_AR,
    W_TRFC
  } work_state_t;

  localparam logic [15:0] CNT_MAX = 16'hffff;

  // A burst length field of zero encodes a full 512-beat page.
  function automatic logic [9:0] burst_len(input logic [8:0] bytes);
    return (bytes == 9'd0) ? 10'd512 : {1'b0, bytes};
  endfunction

  // True on the last cycle of a state that dwells for 'dwell' cycles,
  // given the per-state cycle counter that starts at 0.
  function automatic logic at_end(input logic [15:0] cnt, input int dwell);
    return cnt == 16'(dwell - 1);
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer
//   Auto-refresh interval timer. Counts while the SDRAM is initialised and
//   raises ref_pend once every T_REF cycles; the work FSM clears it when it
//   enters the auto-refresh state.
// Ports:
//   clk_100m  in  system clock
//   rst_n     in  asynchronous active-low reset
//   en        in  high once initialisation has finished
//   clr       in  refresh is being issued this cycle
//   ref_pend  out a refresh is owed to the SDRAM
module sdram_ref_timer #(
  parameter int T_REF = 780
) (
  input  logic clk_100m,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic ref_pend
);

  logic [15:0] ref_cnt;

  // A new interval expiry wins over a simultaneous clear so that a refresh
  // is never lost.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt  <= 16'd0;
      ref_pend <= 1'b0;
    end else if (!en) begin
      ref_cnt  <= 16'd0;
    end else if (ref_cnt == 16'(T_REF - 1)) begin
      ref_cnt  <= 16'd0;
      ref_pend <= 1'b1;
    end else begin
      ref_cnt  <= ref_cnt + 16'd1;
      if (clr) ref_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_ctrl.sv
// sdram_ctrl
//   Sequencing controller for the 100 MHz SDRAM: power-up initialisation,
//   write/read arbitration and periodic auto-refresh. State and cycle count
//   feed the registered command decoder; the strobes pace the datapaths.
// Ports:
//   clk_100m, rst_n           clock, asynchronous active-low reset
//   sdwr_req/sdrd_req         level requests, held until the matching ack
//   sdwr_bytes/sdrd_bytes     burst length in beats (0 = 512)
//   init_state/work_state     FSM states for the decoder
//   cnt_clk                   cycles spent in the current state
//   sys_r_wn                  1 = write transaction, 0 = read
//   sdram_busy                low only when initialised and idle
//   sdwr_ack/sdrd_ack         grant pulses, coincide with W_ACTIVE
//   sdwr_data_en/sdrd_data_vld per-beat data strobes
//   sdwr_done/sdrd_done       completion pulses in the last W_TRP cycle
module sdram_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int T_POWERUP = 20000,
  parameter int T_RP      = 3,
  parameter int T_RFC     = 7,
  parameter int T_MRD     = 2,
  parameter int T_RCD     = 3,
  parameter int CL        = 3,
  parameter int T_WR      = 2,
  parameter int T_REF     = 780
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        sdwr_req,
  input  logic        sdrd_req,
  input  logic [8:0]  sdwr_bytes,
  input  logic [8:0]  sdrd_bytes,
  output logic [3:0]  init_state,
  output logic [3:0]  work_state,
  output logic [15:0] cnt_clk,
  output logic        sys_r_wn,
  output logic        sdram_busy,
  output logic        sdwr_ack,
  output logic        sdrd_ack,
  output logic        sdwr_data_en,
  output logic        sdrd_data_vld,
  output logic        sdwr_done,
  output logic        sdrd_done
);

  init_state_t init_q, init_nxt;
  work_state_t work_q, work_nxt;
  logic [15:0] cnt_nxt;
  logic [9:0]  blen_q;
  logic [15:0] blen_ext;
  logic        last_was_rd;
  logic        grant_wr, grant_rd;
  logic        ref_pend;

  assign init_state = init_q;
  assign work_state = work_q;
  assign blen_ext   = {6'd0, blen_q};

  sdram_ref_timer #(.T_REF(T_REF)) u_ref_timer (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .en       (init_q == I_DONE),
    .clr      (work_nxt == W_AR),
    .ref_pend (ref_pend)
  );

  // Next-state decode for both FSMs. Outputs are registered from these
  // next-state values so that every strobe lines up with its state.
  always_comb begin
    init_nxt = init_q;
    work_nxt = work_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;

    case (init_q)
      I_NOP:           if (at_end(cnt_clk, T_POWERUP)) init_nxt = I_PRECHARGE;
      I_PRECHARGE:     init_nxt = I_TRP;
      I_TRP:           if (at_end(cnt_clk, T_RP)) init_nxt = I_AUTO_REFRESH1;
      I_AUTO_REFRESH1: init_nxt = I_TRF1;
      I_TRF1:          if (at_end(cnt_clk, T_RFC)) init_nxt = I_AUTO_REFRESH2;
      I_AUTO_REFRESH2: init_nxt = I_TRF2;
      I_TRF2:          if (at_end(cnt_clk, T_RFC)) init_nxt = I_MRS;
      I_MRS:           init_nxt = I_TMRD;
      I_TMRD:          if (at_end(cnt_clk, T_MRD)) init_nxt = I_DONE;
      default:         init_nxt = I_DONE;
    endcase

    if (init_q == I_DONE) begin
      case (work_q)
        // Refresh first; on contention serve the type not served last.
        W_IDLE: begin
          if (ref_pend) begin
            work_nxt = W_AR;
          end else if (sdwr_req && (!sdrd_req || last_was_rd)) begin
            work_nxt = W_ACTIVE;
            grant_wr = 1'b1;
          end else if (sdrd_req) begin
            work_nxt = W_ACTIVE;
            grant_rd = 1'b1;
          end
        end
        W_ACTIVE:    work_nxt = W_TRCD;
        W_TRCD:      if (at_end(cnt_clk, T_RCD - 1)) work_nxt = sys_r_wn ? W_WRITE : W_READ;
        W_WRITE:     work_nxt = (blen_q == 10'd1) ? W_TDAL : W_WD;
        W_WD:        if (cnt_clk == blen_ext - 16'd2) work_nxt = W_TDAL;
        W_TDAL:      if (at_end(cnt_clk, T_WR)) work_nxt = W_PRECHARGE;
        W_READ:      work_nxt = W_CL;
        W_CL:        if (at_end(cnt_clk, CL)) work_nxt = W_RD;
        W_RD:        if (cnt_clk == blen_ext - 16'd1) work_nxt = W_PRECHARGE;
        W_PRECHARGE: work_nxt = W_TRP;
        W_TRP:       if (at_end(cnt_clk, T_RP)) work_nxt = W_IDLE;
        W_AR:        work_nxt = W_TRFC;
        W_TRFC:      if (at_end(cnt_clk, T_RFC)) work_nxt = W_IDLE;
        default:     work_nxt = W_IDLE;
      endcase
    end

    if (init_nxt != init_q || work_nxt != work_q)
      cnt_nxt = 16'd0;
    else if (cnt_clk == CNT_MAX)
      cnt_nxt = CNT_MAX;
    else
      cnt_nxt = cnt_clk + 16'd1;
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      init_q        <= I_NOP;
      work_q        <= W_IDLE;
      cnt_clk       <= 16'd0;
      sys_r_wn      <= 1'b1;
      last_was_rd   <= 1'b1;
      blen_q        <= 10'd0;
      sdram_busy    <= 1'b1;
      sdwr_ack      <= 1'b0;
      sdrd_ack      <= 1'b0;
      sdwr_data_en  <= 1'b0;
      sdrd_data_vld <= 1'b0;
      sdwr_done     <= 1'b0;
      sdrd_done     <= 1'b0;
    end else begin
      init_q  <= init_nxt;
      work_q  <= work_nxt;
      cnt_clk <= cnt_nxt;

      if (grant_wr) begin
        sys_r_wn    <= 1'b1;
        last_was_rd <= 1'b0;
        blen_q      <= burst_len(sdwr_bytes);
      end else if (grant_rd) begin
        sys_r_wn    <= 1'b0;
        last_was_rd <= 1'b1;
        blen_q      <= burst_len(sdrd_bytes);
      end

      sdwr_ack      <= grant_wr;
      sdrd_ack      <= grant_rd;
      sdwr_data_en  <= (work_nxt == W_WRITE) || (work_nxt == W_WD);
      sdrd_data_vld <= (work_nxt == W_RD);
      sdwr_done     <= (work_nxt == W_TRP) && at_end(cnt_nxt, T_RP) && sys_r_wn;
      sdrd_done     <= (work_nxt == W_TRP) && at_end(cnt_nxt, T_RP) && !sys_r_wn;
      sdram_busy    <= !((init_nxt == I_DONE) && (work_nxt == W_IDLE));
    end
  end

endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl
//   Directed bench for sdram_ctrl with a shortened power-up wait. Expected
//   dwells and beat counts are hand-derived from the timing parameters.
module tb_sdram_ctrl;
  import sdram_ctrl_pkg::*;

  localparam int T_POWERUP = 20;

  logic        clk_100m = 1'b0;
  logic        rst_n;
  logic        sdwr_req, sdrd_req;
  logic [8:0]  sdwr_bytes, sdrd_bytes;
  logic [3:0]  init_state, work_state;
  logic [15:0] cnt_clk;
  logic        sys_r_wn, sdram_busy, sdwr_ack, sdrd_ack;
  logic        sdwr_data_en, sdrd_data_vld, sdwr_done, sdrd_done;

  int checks = 0;
  int errors = 0;

  int path_st[$];
  int path_dw[$];
  int cyc, n_en, n_vld, n_wdone, n_rdone, bad_done, rwn_hi, rwn_lo, busy_lo;
  int first_en, last_en, first_vld, last_vld, read_cyc, write_cyc;
  logic a_wr, a_rd, a_ok;
  int   a_wait;

  always #5 clk_100m = ~clk_100m;

  sdram_ctrl #(.T_POWERUP(T_POWERUP)) dut (
    .clk_100m      (clk_100m),
    .rst_n         (rst_n),
    .sdwr_req      (sdwr_req),
    .sdrd_req      (sdrd_req),
    .sdwr_bytes    (sdwr_bytes),
    .sdrd_bytes    (sdrd_bytes),
    .init_state    (init_state),
    .work_state    (work_state),
    .cnt_clk       (cnt_clk),
    .sys_r_wn      (sys_r_wn),
    .sdram_busy    (sdram_busy),
    .sdwr_ack      (sdwr_ack),
    .sdrd_ack      (sdrd_ack),
    .sdwr_data_en  (sdwr_data_en),
    .sdrd_data_vld (sdrd_data_vld),
    .sdwr_done     (sdwr_done),
    .sdrd_done     (sdrd_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [8:0] wb, input logic [8:0] rb);
    sdwr_req   = wr;
    sdrd_req   = rd;
    sdwr_bytes = wb;
    sdrd_bytes = rb;
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, " init_state"}, 32'(init_state), I_NOP);
    checkOutput({name, " work_state"}, 32'(work_state), W_IDLE);
    checkOutput({name, " cnt_clk"}, 32'(cnt_clk), 0);
    checkOutput({name, " sys_r_wn"}, 32'(sys_r_wn), 1);
    checkOutput({name, " busy"}, 32'(sdram_busy), 1);
    checkOutput({name, " strobes"}, 32'({sdwr_ack, sdrd_ack, sdwr_data_en, sdrd_data_vld, sdwr_done, sdrd_done}), 0);
  endtask

  // Walk the init sequence from the current sample, checking each state's
  // dwell and that busy stays high until the controller is idle.
  task automatic checkInit(input string name);
    int dw_exp [9];
    int blo;
    dw_exp = '{T_POWERUP, 1, 3, 1, 7, 1, 7, 1, 2};
    blo = 0;
    for (int s = 0; s < 9; s++) begin
      int dw;
      dw = 0;
      checkOutput($sformatf("%s state%0d", name, s), 32'(init_state), s);
      checkOutput($sformatf("%s cnt0 s%0d", name, s), 32'(cnt_clk), 0);
      while (init_state == 4'(s) && dw < 30000) begin
        if (!sdram_busy) blo++;
        dw++;
        @(negedge clk_100m);
      end
      checkOutput($sformatf("%s dwell s%0d", name, s), dw, dw_exp[s]);
    end
    checkOutput({name, " reached done"}, 32'(init_state), I_DONE);
    checkOutput({name, " busy during init"}, blo, 0);
    @(negedge clk_100m);
    checkOutput({name, " busy after done"}, 32'(sdram_busy), 0);
    checkOutput({name, " still done"}, 32'(init_state), I_DONE);
  endtask

  task automatic sampleCycle();
    if (sdwr_data_en) begin
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      n_en++;
    end
    if (sdrd_data_vld) begin
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      n_vld++;
    end
    if (work_state == W_READ && read_cyc < 0) read_cyc = cyc;
    if (work_state == W_WRITE && write_cyc < 0) write_cyc = cyc;
    if (sdwr_done) n_wdone++;
    if (sdrd_done) n_rdone++;
    if ((sdwr_done || sdrd_done) && !(work_state == W_TRP && cnt_clk == 16'd2)) bad_done++;
    if (sys_r_wn) rwn_hi++; else rwn_lo++;
    if (!sdram_busy) busy_lo++;
    cyc++;
  endtask

  // Follow the work FSM through path_st/path_dw, then expect one W_IDLE sample.
  task automatic runPath(input string name);
    cyc = 0; n_en = 0; n_vld = 0; n_wdone = 0; n_rdone = 0; bad_done = 0;
    rwn_hi = 0; rwn_lo = 0; busy_lo = 0;
    first_en = -1; last_en = -1; first_vld = -1; last_vld = -1;
    read_cyc = -1; write_cyc = -1;
    foreach (path_st[k]) begin
      int dw;
      dw = 0;
      checkOutput($sformatf("%s state%0d", name, k), 32'(work_state), path_st[k]);
      checkOutput($sformatf("%s cnt0 k%0d", name, k), 32'(cnt_clk), 0);
      while (work_state == 4'(path_st[k]) && dw < 1000) begin
        sampleCycle();
        dw++;
        @(negedge clk_100m);
      end
      checkOutput($sformatf("%s dwell k%0d", name, k), dw, path_dw[k]);
    end
    checkOutput({name, " back to idle"}, 32'(work_state), W_IDLE);
    checkOutput({name, " busy during path"}, busy_lo, 0);
    checkOutput({name, " done at last trp"}, bad_done, 0);
  endtask

  task automatic waitAck();
    a_wait = 0;
    while (!sdwr_ack && !sdrd_ack && a_wait < 2000) begin
      @(negedge clk_100m);
      a_wait++;
    end
    a_wr = sdwr_ack;
    a_rd = sdrd_ack;
    a_ok = (a_wait < 2000);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (sdram_busy && n < 2000) begin
      @(negedge clk_100m);
      n++;
    end
    checkOutput({name, " idle timeout"}, 32'(n < 2000), 1);
  endtask

  // Both requests together; the first grant must match wr_first.
  task automatic pairTest(input string name, input logic wr_first);
    applyStimulus(1'b1, 1'b1, 9'd2, 9'd2);
    waitAck();
    checkOutput({name, " ack1 timeout"}, 32'(a_ok), 1);
    checkOutput({name, " ack1 write"}, 32'(a_wr), 32'(wr_first));
    checkOutput({name, " ack1 read"}, 32'(a_rd), 32'(!wr_first));
    checkOutput({name, " ack1 active"}, 32'(work_state), W_ACTIVE);
    checkOutput({name, " ack1 r_wn"}, 32'(sys_r_wn), 32'(wr_first));
    if (a_wr) sdwr_req = 1'b0;
    else if (a_rd) sdrd_req = 1'b0;
    else applyStimulus(1'b0, 1'b0, 9'd2, 9'd2);
    @(negedge clk_100m);
    checkOutput({name, " ack is one cycle"}, 32'(sdwr_ack | sdrd_ack), 0);
    waitAck();
    checkOutput({name, " ack2 timeout"}, 32'(a_ok), 1);
    checkOutput({name, " ack2 write"}, 32'(a_wr), 32'(!wr_first));
    checkOutput({name, " ack2 read"}, 32'(a_rd), 32'(wr_first));
    checkOutput({name, " ack2 r_wn"}, 32'(sys_r_wn), 32'(!wr_first));
    applyStimulus(1'b0, 1'b0, 9'd2, 9'd2);
    waitIdle(name);
  endtask

  task automatic writeTest(input string name, input logic [8:0] bytes, input int wd_dwell, input int beats);
    applyStimulus(1'b1, 1'b0, bytes, 9'd0);
    waitAck();
    checkOutput({name, " ack"}, 32'(a_wr & a_ok), 1);
    checkOutput({name, " r_wn at ack"}, 32'(sys_r_wn), 1);
    sdwr_req = 1'b0;
    if (wd_dwell > 0) begin
      path_st = '{W_ACTIVE, W_TRCD, W_WRITE, W_WD, W_TDAL, W_PRECHARGE, W_TRP};
      path_dw = '{1, 2, 1, wd_dwell, 2, 1, 3};
    end else begin
      path_st = '{W_ACTIVE, W_TRCD, W_WRITE, W_TDAL, W_PRECHARGE, W_TRP};
      path_dw = '{1, 2, 1, 2, 1, 3};
    end
    runPath(name);
    checkOutput({name, " beats"}, n_en, beats);
    checkOutput({name, " beats contiguous"}, last_en - first_en + 1, beats);
    checkOutput({name, " first beat at W_WRITE"}, first_en, 3);
    checkOutput({name, " write state cycle"}, write_cyc, 3);
    checkOutput({name, " done pulses"}, n_wdone, 1);
    checkOutput({name, " no read done"}, n_rdone, 0);
    checkOutput({name, " busy low at idle"}, 32'(sdram_busy), 0);
  endtask

  task automatic checkRead512(input string name);
    checkOutput({name, " beats"}, n_vld, 512);
    checkOutput({name, " beats contiguous"}, last_vld - first_vld + 1, 512);
    checkOutput({name, " read state cycle"}, read_cyc, 3);
    checkOutput({name, " first beat CL+1 after read"}, first_vld, 7);
    checkOutput({name, " r_wn high cycles"}, rwn_hi, 0);
    checkOutput({name, " done pulses"}, n_rdone, 1);
    checkOutput({name, " no write beats"}, n_en, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 9'd0, 9'd0);
    repeat (3) @(negedge clk_100m);
    checkResetValues("reset");
    rst_n = 1'b1;
    checkInit("init");

    // After reset a contended pair goes write first, then read.
    pairTest("pair1", 1'b1);

    writeTest("wr4", 9'd4, 3, 4);
    writeTest("wr1", 9'd1, 0, 1);

    // Last served was a write, so contention now favours the read.
    pairTest("pair2", 1'b0);

    applyStimulus(1'b0, 1'b1, 9'd0, 9'd0);
    waitAck();
    checkOutput("rd512 ack", 32'(a_rd & a_ok), 1);
    checkOutput("rd512 r_wn at ack", 32'(sys_r_wn), 0);
    sdrd_req = 1'b0;
    path_st = '{W_ACTIVE, W_TRCD, W_READ, W_CL, W_RD, W_PRECHARGE, W_TRP};
    path_dw = '{1, 2, 1, 3, 512, 1, 3};
    runPath("rd512");
    checkRead512("rd512");

    // Idle refresh fixes the timer phase for the deferred-refresh case.
    begin
      int n;
      n = 0;
      while (work_state != W_AR && n < 2000) begin
        @(negedge clk_100m);
        n++;
      end
    end
    path_st = '{W_AR, W_TRFC};
    path_dw = '{1, 7};
    runPath("ref1");
    checkOutput("ref1 no beats", n_en + n_vld, 0);

    repeat (400) @(negedge clk_100m);
    applyStimulus(1'b0, 1'b1, 9'd3, 9'd0);
    waitAck();
    checkOutput("rdref ack", 32'(a_rd & a_ok), 1);
    sdrd_req = 1'b0;
    path_st = '{W_ACTIVE, W_TRCD, W_READ, W_CL, W_RD, W_PRECHARGE, W_TRP};
    path_dw = '{1, 2, 1, 3, 512, 1, 3};
    fork
      runPath("rdref");
      begin
        repeat (100) @(negedge clk_100m);
        sdwr_req = 1'b1;
      end
    join
    checkRead512("rdref");
    @(negedge clk_100m);
    path_st = '{W_AR, W_TRFC};
    path_dw = '{1, 7};
    runPath("ref2");
    waitAck();
    checkOutput("wr after ref ack", 32'(a_wr & a_ok), 1);
    checkOutput("wr after ref delay", a_wait, 1);
    checkOutput("wr after ref active", 32'(work_state), W_ACTIVE);
    sdwr_req = 1'b0;
    waitIdle("wr after ref");

    // Reset in the middle of a write burst.
    applyStimulus(1'b1, 1'b0, 9'd8, 9'd0);
    waitAck();
    checkOutput("rstmid ack", 32'(a_wr & a_ok), 1);
    sdwr_req = 1'b0;
    begin
      int n;
      n = 0;
      while (work_state != W_WD && n < 100) begin
        @(negedge clk_100m);
        n++;
      end
    end
    @(negedge clk_100m);
    checkOutput("rstmid in W_WD", 32'(work_state), W_WD);
    checkOutput("rstmid data_en before", 32'(sdwr_data_en), 1);
    rst_n = 1'b0;
    #1;
    checkResetValues("rstmid");
    @(negedge clk_100m);
    @(negedge clk_100m);
    rst_n = 1'b1;
    checkInit("reinit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
